// File: rtl/dequantizer_multi_table.sv
// JPEG dequantizer: coefficient x runtime-loadable quant-table entry, clamped to the signed integer field, emitted in Q fixed point.
// Latency 2 registered stages (S1 lookup, S2 multiply/clamp); input ready drops only when both stages hold and downstream stalls.
module dequantizer_multi_table #(
  parameter int PIXEL_BIT    = 12,
  parameter int TABLO_BIT    = 8,
  parameter int TABLO_SAYISI = 4,
  parameter int Q_BIT        = 32,
  parameter int Q_FRAC       = 16,
  parameter int BLOCK_BIT    = 3,
  parameter int TS_BIT       = (TABLO_SAYISI > 1) ? $clog2(TABLO_SAYISI) : 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 tablo_yaz_gecerli_i,
  input  logic [TS_BIT-1:0]    tablo_yaz_sec_i,
  input  logic [5:0]           tablo_yaz_adres_i,
  input  logic [TABLO_BIT-1:0] tablo_yaz_veri_i,
  input  logic [PIXEL_BIT-1:0] zig_veri_i,
  input  logic [BLOCK_BIT-1:0] zig_veri_row_i,
  input  logic [BLOCK_BIT-1:0] zig_veri_col_i,
  input  logic [TS_BIT-1:0]    zig_tablo_sec_i,
  input  logic                 zig_veri_gecerli_i,
  input  logic                 zig_blok_son_i,
  output logic                 zig_veri_hazir_o,
  output logic [Q_BIT-1:0]     idct_veri_o,
  output logic [BLOCK_BIT-1:0] idct_veri_row_o,
  output logic [BLOCK_BIT-1:0] idct_veri_col_o,
  output logic                 idct_veri_gecerli_o,
  output logic                 idct_blok_son_o,
  output logic                 idct_doygun_o,
  input  logic                 idct_veri_hazir_i
);
  localparam int I_BIT = Q_BIT - Q_FRAC;
  localparam int P_BIT = PIXEL_BIT + TABLO_BIT + 1;
  localparam int W_BIT = ((P_BIT > I_BIT) ? P_BIT : I_BIT) + 1;
  localparam logic signed [W_BIT-1:0] MAKS = {{(W_BIT-I_BIT+1){1'b0}}, {(I_BIT-1){1'b1}}};
  localparam logic signed [W_BIT-1:0] MIN  = ~MAKS;

  // Annex K.1 luminance table, row-major; every table powers up with it
  localparam logic [7:0] K1 [64] = '{
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  logic [TABLO_BIT-1:0] tablo_q [TABLO_SAYISI][64];
  logic [TABLO_BIT-1:0] tablo_d [TABLO_SAYISI][64];

  logic                 baslangic_q, baslangic_d;
  logic [TS_BIT-1:0]    aktif_tablo_q, aktif_tablo_d;

  logic                 s1_v_q, s1_v_d, s1_son_q, s1_son_d;
  logic [PIXEL_BIT-1:0] s1_coef_q, s1_coef_d;
  logic [BLOCK_BIT-1:0] s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic [TABLO_BIT-1:0] s1_giris_q, s1_giris_d;

  logic                 s2_v_q, s2_v_d, s2_son_q, s2_son_d, doygun_q, doygun_d;
  logic [Q_BIT-1:0]     cikis_q, cikis_d;
  logic [BLOCK_BIT-1:0] s2_row_q, s2_row_d, s2_col_q, s2_col_d;

  logic                 s1_yukle, s2_yukle, kabul;
  logic [TS_BIT-1:0]    sec_gecerli, oku_tablo;
  logic [5:0]           oku_adres;
  logic signed [P_BIT-1:0] carpim;
  logic signed [W_BIT-1:0] genis, kirp;
  logic                 kirpildi;

  always_comb begin
    tablo_d = tablo_q;
    if (tablo_yaz_gecerli_i && (int'({1'b0, tablo_yaz_sec_i}) < TABLO_SAYISI))
      tablo_d[tablo_yaz_sec_i][tablo_yaz_adres_i] = tablo_yaz_veri_i;
  end

  // Lookup reads the registered table, so a same-cycle write is seen only by later beats
  always_comb begin
    sec_gecerli = (int'({1'b0, zig_tablo_sec_i}) < TABLO_SAYISI) ? zig_tablo_sec_i : '0;
    oku_tablo   = baslangic_q ? sec_gecerli : aktif_tablo_q;
    oku_adres   = 6'(int'(zig_veri_row_i) * 8 + int'(zig_veri_col_i));
  end

  always_comb begin
    carpim = P_BIT'($signed(s1_coef_q)) * P_BIT'($signed({1'b0, s1_giris_q}));
    genis  = W_BIT'(carpim);
    kirp     = genis;
    kirpildi = 1'b0;
    if (genis > MAKS) begin
      kirp     = MAKS;
      kirpildi = 1'b1;
    end else if (genis < MIN) begin
      kirp     = MIN;
      kirpildi = 1'b1;
    end
  end

  always_comb begin
    s2_yukle = !s2_v_q || idct_veri_hazir_i;
    s1_yukle = !s1_v_q || s2_yukle;
    kabul    = zig_veri_gecerli_i && s1_yukle;

    baslangic_d   = baslangic_q;
    aktif_tablo_d = aktif_tablo_q;
    s1_v_d     = s1_v_q;
    s1_son_d   = s1_son_q;
    s1_coef_d  = s1_coef_q;
    s1_row_d   = s1_row_q;
    s1_col_d   = s1_col_q;
    s1_giris_d = s1_giris_q;
    s2_v_d   = s2_v_q;
    s2_son_d = s2_son_q;
    doygun_d = doygun_q;
    cikis_d  = cikis_q;
    s2_row_d = s2_row_q;
    s2_col_d = s2_col_q;

    if (s1_yukle) s1_v_d = zig_veri_gecerli_i;
    if (kabul) begin
      baslangic_d = zig_blok_son_i;
      if (baslangic_q) aktif_tablo_d = sec_gecerli;
      s1_son_d   = zig_blok_son_i;
      s1_coef_d  = zig_veri_i;
      s1_row_d   = zig_veri_row_i;
      s1_col_d   = zig_veri_col_i;
      s1_giris_d = tablo_q[oku_tablo][oku_adres];
    end

    if (s2_yukle) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_son_d = s1_son_q;
        s2_row_d = s1_row_q;
        s2_col_d = s1_col_q;
        doygun_d = kirpildi;
        cikis_d  = Q_BIT'(kirp) << Q_FRAC;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int t = 0; t < TABLO_SAYISI; t++)
        for (int i = 0; i < 64; i++)
          tablo_q[t][i] <= TABLO_BIT'(K1[i]);
      baslangic_q   <= 1'b1;
      aktif_tablo_q <= '0;
      s1_v_q     <= 1'b0;
      s1_son_q   <= 1'b0;
      s1_coef_q  <= '0;
      s1_row_q   <= '0;
      s1_col_q   <= '0;
      s1_giris_q <= '0;
      s2_v_q   <= 1'b0;
      s2_son_q <= 1'b0;
      doygun_q <= 1'b0;
      cikis_q  <= '0;
      s2_row_q <= '0;
      s2_col_q <= '0;
    end else begin
      tablo_q       <= tablo_d;
      baslangic_q   <= baslangic_d;
      aktif_tablo_q <= aktif_tablo_d;
      s1_v_q     <= s1_v_d;
      s1_son_q   <= s1_son_d;
      s1_coef_q  <= s1_coef_d;
      s1_row_q   <= s1_row_d;
      s1_col_q   <= s1_col_d;
      s1_giris_q <= s1_giris_d;
      s2_v_q   <= s2_v_d;
      s2_son_q <= s2_son_d;
      doygun_q <= doygun_d;
      cikis_q  <= cikis_d;
      s2_row_q <= s2_row_d;
      s2_col_q <= s2_col_d;
    end
  end

  assign zig_veri_hazir_o    = s1_yukle;
  assign idct_veri_o         = cikis_q;
  assign idct_veri_row_o     = s2_row_q;
  assign idct_veri_col_o     = s2_col_q;
  assign idct_veri_gecerli_o = s2_v_q;
  assign idct_blok_son_o     = s2_son_q;
  assign idct_doygun_o       = doygun_q;
endmodule

// File: tb/tb_dequantizer_multi_table.sv
// Bench for dequantizer_multi_table: directed and randomized blocks scored against a plain-arithmetic model.
module tb_dequantizer_multi_table;
  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        tablo_yaz_gecerli_i;
  logic [1:0]  tablo_yaz_sec_i;
  logic [5:0]  tablo_yaz_adres_i;
  logic [7:0]  tablo_yaz_veri_i;
  logic [11:0] zig_veri_i;
  logic [2:0]  zig_veri_row_i, zig_veri_col_i;
  logic [1:0]  zig_tablo_sec_i;
  logic        zig_veri_gecerli_i, zig_blok_son_i, zig_veri_hazir_o;
  logic [31:0] idct_veri_o;
  logic [2:0]  idct_veri_row_o, idct_veri_col_o;
  logic        idct_veri_gecerli_o, idct_blok_son_o, idct_doygun_o, idct_veri_hazir_i;

  always #5 clk_i = ~clk_i;

  dequantizer_multi_table dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .tablo_yaz_gecerli_i(tablo_yaz_gecerli_i), .tablo_yaz_sec_i(tablo_yaz_sec_i),
    .tablo_yaz_adres_i(tablo_yaz_adres_i), .tablo_yaz_veri_i(tablo_yaz_veri_i),
    .zig_veri_i(zig_veri_i), .zig_veri_row_i(zig_veri_row_i), .zig_veri_col_i(zig_veri_col_i),
    .zig_tablo_sec_i(zig_tablo_sec_i), .zig_veri_gecerli_i(zig_veri_gecerli_i),
    .zig_blok_son_i(zig_blok_son_i), .zig_veri_hazir_o(zig_veri_hazir_o),
    .idct_veri_o(idct_veri_o), .idct_veri_row_o(idct_veri_row_o), .idct_veri_col_o(idct_veri_col_o),
    .idct_veri_gecerli_o(idct_veri_gecerli_o), .idct_blok_son_o(idct_blok_son_o),
    .idct_doygun_o(idct_doygun_o), .idct_veri_hazir_i(idct_veri_hazir_i)
  );

  typedef struct packed {
    logic [31:0] dat;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        son;
    logic        doy;
  } out_t;

  typedef struct packed {
    logic [11:0] coef;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [1:0]  sec;
    logic        son;
  } beat_t;

  int k1 [64] = '{16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
                  14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
                  18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
                  49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int   m_tab [4][64];
  bit   m_start;
  int   m_tbl;
  out_t exp_q[$];
  out_t got_q[$];

  int   checks = 0;
  int   errors = 0;

  int   s_occ;
  logic s_zrdy, s_ovld;
  bit   s_acc, s_xfer;
  out_t s_out;

  task automatic model_reset();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 64; i++) m_tab[t][i] = k1[i];
    m_start = 1'b1;
    m_tbl   = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Product of signed coefficient and unsigned entry, clamped to 16 integer bits, scaled by 2^16
  function automatic out_t model(beat_t b);
    int t, e, c, p;
    out_t r;
    t = int'(b.sec);
    if (t >= 4) t = 0;
    if (m_start) m_tbl = t;
    else t = m_tbl;
    m_start = b.son;
    e = m_tab[t][int'(b.row) * 8 + int'(b.col)];
    c = $signed(b.coef);
    p = c * e;
    r.doy = 1'b0;
    if (p > 32767) begin p = 32767; r.doy = 1'b1; end
    if (p < -32768) begin p = -32768; r.doy = 1'b1; end
    r.dat = 32'(p * 65536);
    r.row = b.row;
    r.col = b.col;
    r.son = b.son;
    return r;
  endfunction

  // One clock cycle: drive at negedge, sample before posedge, advance model tables at posedge
  task automatic step(input beat_t b, input bit v, input bit rdy,
                      input bit wr, input int wsel, input int wadr, input int wdat);
    zig_veri_i          = b.coef;
    zig_veri_row_i      = b.row;
    zig_veri_col_i      = b.col;
    zig_tablo_sec_i     = b.sec;
    zig_blok_son_i      = b.son;
    zig_veri_gecerli_i  = v;
    idct_veri_hazir_i   = rdy;
    tablo_yaz_gecerli_i = wr;
    tablo_yaz_sec_i     = 2'(wsel);
    tablo_yaz_adres_i   = 6'(wadr);
    tablo_yaz_veri_i    = 8'(wdat);
    #1;
    s_occ  = exp_q.size() - got_q.size();
    s_zrdy = zig_veri_hazir_o;
    s_ovld = idct_veri_gecerli_o;
    s_out  = {idct_veri_o, idct_veri_row_o, idct_veri_col_o, idct_blok_son_o, idct_doygun_o};
    s_acc  = v && zig_veri_hazir_o;
    s_xfer = idct_veri_gecerli_o && rdy;
    if (s_xfer) got_q.push_back(s_out);
    if (s_acc) exp_q.push_back(model(b));
    @(posedge clk_i);
    if (wr) m_tab[wsel][wadr] = wdat;
    @(negedge clk_i);
  endtask

  task automatic drain();
    beat_t z = '0;
    int n = 0;
    while (exp_q.size() > got_q.size() && n < 300) begin
      step(z, 1'b0, 1'b1, 1'b0, 0, 0, 0);
      n++;
    end
  endtask

  function automatic beat_t mk(int coef, int row, int col, int sec, bit son);
    beat_t b;
    b.coef = 12'(coef);
    b.row  = 3'(row);
    b.col  = 3'(col);
    b.sec  = 2'(sec);
    b.son  = son;
    return b;
  endfunction

  task automatic test_reset();
    rstn_i = 1'b0;
    zig_veri_gecerli_i = 1'b0; zig_veri_i = '0; zig_veri_row_i = '0; zig_veri_col_i = '0;
    zig_tablo_sec_i = '0; zig_blok_son_i = 1'b0; idct_veri_hazir_i = 1'b0;
    tablo_yaz_gecerli_i = 1'b0; tablo_yaz_sec_i = '0; tablo_yaz_adres_i = '0; tablo_yaz_veri_i = '0;
    model_reset();
    repeat (3) @(negedge clk_i);
    checks++;
    if ({idct_veri_gecerli_o, idct_veri_o, idct_veri_row_o, idct_veri_col_o, idct_blok_son_o, idct_doygun_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b dat=%h row=%0d col=%0d son=%b doy=%b required all zero",
               idct_veri_gecerli_o, idct_veri_o, idct_veri_row_o, idct_veri_col_o, idct_blok_son_o, idct_doygun_o);
    end
    checks++;
    if (zig_veri_hazir_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", zig_veri_hazir_o); end
    rstn_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (idct_veri_gecerli_o !== 1'b0 || zig_veri_hazir_o !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got vld=%b rdy=%b required 0/1", idct_veri_gecerli_o, zig_veri_hazir_o);
    end
  endtask

  task automatic test_k1_block();
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 64; i++) begin
      step(mk(1, i / 8, i % 8, 0, i == 63), 1'b1, 1'b1, 1'b0, 0, 0, 0);
      if (i == 0) begin
        checks++;
        if (idct_veri_gecerli_o !== 1'b0) begin errors++; $display("FAIL latency_early got vld=%b required 0", idct_veri_gecerli_o); end
      end
      if (i == 1) begin
        checks++;
        if (idct_veri_gecerli_o !== 1'b1) begin errors++; $display("FAIL latency_two got vld=%b required 1", idct_veri_gecerli_o); end
      end
    end
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL k1_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL k1_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_q.size() != 64 || got_q[0].dat !== 32'h0010_0000 || got_q[63].dat !== 32'h0063_0000) begin
      errors++;
      $display("FAIL k1_ends got %0d beats required 64 with first 0x00100000 last 0x00630000", got_q.size());
    end
  endtask

  task automatic test_write_sel();
    exp_q.delete(); got_q.delete();
    step('0, 1'b0, 1'b1, 1'b1, 2, 9, 200);
    step(mk(5, 0, 0, 2, 1'b0), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(-3, 1, 1, 1, 1'b0), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(7, 2, 3, 1, 1'b0), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(-1, 7, 7, 1, 1'b1), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL wsel_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL wsel_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_q.size() < 2 || got_q[1].dat !== 32'hFDA8_0000 || got_q[1].doy !== 1'b0) begin
      errors++;
      $display("FAIL wsel_minus600 got %h required fda80000 doy 0", (got_q.size() > 1) ? got_q[1].dat : 32'hx);
    end
  endtask

  task automatic test_saturation();
    exp_q.delete(); got_q.delete();
    step('0, 1'b0, 1'b1, 1'b1, 1, 0, 255);
    step(mk(127, 0, 0, 1, 1'b0), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(-2048, 0, 0, 0, 1'b0), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(2047, 0, 0, 0, 1'b1), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL sat_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL sat_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_q.size() != 3 || {got_q[0].dat, got_q[0].doy} !== {32'h7E81_0000, 1'b0}
        || {got_q[1].dat, got_q[1].doy} !== {32'h8000_0000, 1'b1}
        || {got_q[2].dat, got_q[2].doy} !== {32'h7FFF_0000, 1'b1}) begin
      errors++;
      $display("FAIL sat_values got %0d beats required 7e810000/0, 80000000/1, 7fff0000/1", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int   tbls [3] = '{0, 1, 3};
    bit   pv, pr, vv, rdy, stuck;
    out_t po;
    beat_t b;
    exp_q.delete(); got_q.delete();
    for (int k = 0; k < 40; k++)
      step('0, 1'b0, 1'b1, 1'b1, (k % 2) ? 3 : 1, $urandom_range(63), (k % 5 == 0) ? 255 : $urandom_range(255));
    pv = 1'b0; pr = 1'b1; po = '0; stuck = 1'b0;
    for (int blk = 0; blk < 3 && !stuck; blk++) begin
      for (int i = 0; i < 64 && !stuck; i++) begin
        b = mk($urandom, i / 8, i % 8, (i == 0) ? tbls[blk] : $urandom_range(3), i == 63);
        vv = 1'b0;
        for (int n = 0; n <= 1000; n++) begin
          if (n == 1000) begin
            stuck = 1'b1; checks++; errors++;
            $display("FAIL b2b_accept_timeout blk=%0d beat=%0d", blk, i);
            break;
          end
          if (!vv) vv = ($urandom_range(3) != 0);
          rdy = $urandom_range(1);
          step(b, vv, rdy, 1'b0, 0, 0, 0);
          if (pv && !pr) begin
            checks++;
            if (s_ovld !== 1'b1 || s_out !== po) begin
              errors++; $display("FAIL stall_hold got vld=%b %h required 1 %h", s_ovld, s_out, po);
            end
          end
          checks++;
          if (s_zrdy !== !(s_occ == 2 && !rdy)) begin
            errors++; $display("FAIL ready_rule got %b required %b occ=%0d", s_zrdy, !(s_occ == 2 && !rdy), s_occ);
          end
          pv = s_ovld; pr = rdy; po = s_out;
          if (s_acc) break;
        end
      end
    end
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_collision();
    exp_q.delete(); got_q.delete();
    step(mk(1, 0, 5, 0, 1'b0), 1'b1, 1'b1, 1'b1, 0, 5, 77);
    step(mk(1, 0, 5, 0, 1'b1), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL coll_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL coll_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_q.size() != 2 || got_q[0].dat !== 32'h0028_0000 || got_q[1].dat !== 32'h004D_0000) begin
      errors++; $display("FAIL coll_old_new got %0d beats required 00280000 then 004d0000", got_q.size());
    end
  endtask

  task automatic test_reset_midblock();
    exp_q.delete(); got_q.delete();
    step(mk(1, 0, 0, 3, 1'b0), 1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(mk(1, 0, 1, 3, 1'b0), 1'b1, 1'b0, 1'b0, 0, 0, 0);
    checks++;
    if (idct_veri_gecerli_o !== 1'b1 || zig_veri_hazir_o !== 1'b0) begin
      errors++; $display("FAIL midrst_full got vld=%b rdy=%b required 1/0", idct_veri_gecerli_o, zig_veri_hazir_o);
    end
    #2 rstn_i = 1'b0;
    #1;
    checks++;
    if (idct_veri_gecerli_o !== 1'b0 || zig_veri_hazir_o !== 1'b1) begin
      errors++; $display("FAIL midrst_async got vld=%b rdy=%b required 0/1", idct_veri_gecerli_o, zig_veri_hazir_o);
    end
    @(negedge clk_i);
    rstn_i = 1'b1;
    model_reset();
    step('0, 1'b0, 1'b1, 1'b1, 2, 9, 150);
    step(mk(1, 1, 1, 2, 1'b0), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(2, 1, 1, 0, 1'b1), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(1, 0, 0, 1, 1'b1), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    step(mk(1, 1, 2, 2, 1'b1), 1'b1, 1'b1, 1'b0, 0, 0, 0);
    drain();
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_beat%0d got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (got_q.size() != 4 || got_q[0].dat !== 32'h0096_0000 || got_q[1].dat !== 32'h012C_0000
        || got_q[2].dat !== 32'h0010_0000 || got_q[3].dat !== 32'h000E_0000) begin
      errors++; $display("FAIL midrst_values got %0d beats required 00960000 012c0000 00100000 000e0000", got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_k1_block();
    test_write_sel();
    test_saturation();
    test_back_to_back();
    test_collision();
    test_reset_midblock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
